// File: rtl/pid_pkg.sv
// Shared types and constants for the PID parameter commit block.
package pid_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        CHECK,
        PEND
    } state_t;

    localparam int unsigned KP_MSB = 31;
    localparam int unsigned KP_LSB = 24;
    localparam int unsigned KI_MSB = 23;
    localparam int unsigned KI_LSB = 16;
    localparam int unsigned KD_MSB = 15;
    localparam int unsigned KD_LSB = 8;
    localparam int unsigned SP_MSB = 7;
    localparam int unsigned SP_LSB = 0;

    localparam logic [7:0] PID_DEF_KP = 8'h4A;
    localparam logic [7:0] PID_DEF_KI = 8'h23;
    localparam logic [7:0] PID_DEF_KD = 8'h00;
    localparam logic [7:0] PID_DEF_SP = 8'h10;

    localparam logic [3:0] ERR_MAX = 4'd15;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input, with selectable reset level.
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pid_param_commit.sv
// Validates SPI frames by counting sck edges per CS window, stages good frames,
// and commits them to the PID coefficient registers only on a PID sample strobe.
module pid_param_commit
    import pid_pkg::*;
#(
    parameter int unsigned BITS   = 32,
    parameter logic [7:0]  DEF_KP = PID_DEF_KP,
    parameter logic [7:0]  DEF_KI = PID_DEF_KI,
    parameter logic [7:0]  DEF_KD = PID_DEF_KD,
    parameter logic [7:0]  DEF_SP = PID_DEF_SP
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            cs,
    input  logic            sck,
    input  logic [BITS-1:0] frame,
    input  logic            pid_stb,
    output logic [7:0]      kp,
    output logic [7:0]      ki,
    output logic [7:0]      kd,
    output logic [7:0]      sp,
    output logic            param_upd,
    output logic            busy,
    output logic [3:0]      err_cnt
);

    localparam int unsigned   BCW     = $clog2(BITS) + 2;
    localparam logic [BCW-1:0] BC_FULL = BCW'(BITS);
    localparam logic [BCW-1:0] BC_MAX  = BCW'(BITS + 1);

    logic cs_s, sck_s, cs_q, sck_q;
    logic cs_fall, cs_rise, sck_fall;

    state_t         state_q, state_d;
    logic [BCW-1:0] bc;
    logic [31:0]    staging;

    logic bc_clr, bc_inc, stage_ld, commit, err_inc;

    sync2 #(.RST_VAL(1'b1)) u_sync_cs (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (cs),
        .q       (cs_s)
    );

    sync2 #(.RST_VAL(1'b0)) u_sync_sck (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (sck),
        .q       (sck_s)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_q  <= 1'b1;
            sck_q <= 1'b0;
        end else begin
            cs_q  <= cs_s;
            sck_q <= sck_s;
        end
    end

    assign cs_fall  = !cs_s && cs_q;
    assign cs_rise  = cs_s && !cs_q;
    assign sck_fall = !sck_s && sck_q;
    assign busy     = (state_q != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        bc_clr   = 1'b0;
        bc_inc   = 1'b0;
        stage_ld = 1'b0;
        commit   = 1'b0;
        err_inc  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d = RECV;
                    bc_clr  = 1'b1;
                end
            end
            RECV: begin
                if (cs_rise) begin
                    state_d = CHECK;
                end else if (sck_fall && !cs_s) begin
                    bc_inc = 1'b1;
                end
            end
            CHECK: begin
                if (bc == BC_FULL) begin
                    stage_ld = 1'b1;
                    state_d  = PEND;
                end else begin
                    err_inc = 1'b1;
                    state_d = IDLE;
                end
            end
            PEND: begin
                // A strobe coinciding with a new frame still commits the staged set first.
                if (pid_stb) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end
                if (cs_fall) begin
                    bc_clr  = 1'b1;
                    state_d = RECV;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bc        <= '0;
            staging   <= '0;
            err_cnt   <= '0;
            param_upd <= 1'b0;
            kp        <= DEF_KP;
            ki        <= DEF_KI;
            kd        <= DEF_KD;
            sp        <= DEF_SP;
        end else begin
            param_upd <= commit;
            if (bc_clr) begin
                bc <= '0;
            end else if (bc_inc && (bc != BC_MAX)) begin
                bc <= bc + BCW'(1);
            end
            if (stage_ld) begin
                staging <= frame[31:0];
            end
            if (err_inc && (err_cnt != ERR_MAX)) begin
                err_cnt <= err_cnt + 4'd1;
            end
            if (commit) begin
                kp <= staging[KP_MSB:KP_LSB];
                ki <= staging[KI_MSB:KI_LSB];
                kd <= staging[KD_MSB:KD_LSB];
                sp <= staging[SP_MSB:SP_LSB];
            end
        end
    end

endmodule

// File: tb/tb_pid_param_commit.sv
// Self-checking bench for pid_param_commit: commits are scoreboarded against param_upd pulses.
module tb_pid_param_commit;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        cs      = 1'b1;
    logic        sck     = 1'b0;
    logic        pid_stb = 1'b0;
    logic [31:0] frame   = '0;
    logic [7:0]  kp, ki, kd, sp;
    logic        param_upd, busy;
    logic [3:0]  err_cnt;

    int n_cmp   = 0;
    int n_mis   = 0;
    int upd_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;

    localparam logic [31:0] DEFAULTS = 32'h4A23_0010;

    always #5 clk = ~clk;

    pid_param_commit #(
        .BITS   (32),
        .DEF_KP (8'h4A),
        .DEF_KI (8'h23),
        .DEF_KD (8'h00),
        .DEF_SP (8'h10)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cs        (cs),
        .sck       (sck),
        .frame     (frame),
        .pid_stb   (pid_stb),
        .kp        (kp),
        .ki        (ki),
        .kd        (kd),
        .sp        (sp),
        .param_upd (param_upd),
        .busy      (busy),
        .err_cnt   (err_cnt)
    );

    // Every param_upd pulse must match the oldest expected commit.
    always @(negedge clk) begin
        if (reset_n && param_upd) begin
            upd_cnt++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_mis++;
                $display("FAIL unexpected_upd: got commit %h, required no commit", {kp, ki, kd, sp});
            end else begin
                mon_exp = exp_q.pop_front();
                if ({kp, ki, kd, sp} !== mon_exp) begin
                    n_mis++;
                    $display("FAIL commit_value: got %h, required %h", {kp, ki, kd, sp}, mon_exp);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_bits(input int n);
        for (int i = 0; i < n; i++) begin
            sck = 1'b1;
            #20;
            sck = 1'b0;
            #20;
        end
    endtask

    task automatic spi_frame(input int n, input logic [31:0] data);
        frame = data;
        cs = 1'b0;
        #40;
        spi_bits(n);
        #40;
        cs = 1'b1;
    endtask

    task automatic strobe();
        pid_stb = 1'b1;
        @(posedge clk);
        #1;
        pid_stb = 1'b0;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        cs      = 1'b1;
        sck     = 1'b0;
        pid_stb = 1'b0;
        frame   = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc(3);
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if ({kp, ki, kd, sp} !== DEFAULTS) begin
            n_mis++;
            $display("FAIL reset_outputs: got %h, required %h", {kp, ki, kd, sp}, DEFAULTS);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_mis++;
            $display("FAIL reset_busy: got %b, required 0", busy);
        end
        n_cmp++;
        if (err_cnt !== 4'd0) begin
            n_mis++;
            $display("FAIL reset_err: got %0d, required 0", err_cnt);
        end
        n_cmp++;
        if (param_upd !== 1'b0) begin
            n_mis++;
            $display("FAIL reset_upd: got %b, required 0", param_upd);
        end
    endtask

    task automatic test_commit();
        int u0;
        u0 = upd_cnt;
        spi_frame(32, 32'h11223344);
        cyc(5);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_mis++;
            $display("FAIL pend_busy: got %b, required 1", busy);
        end
        exp_q.push_back(32'h11223344);
        strobe();
        n_cmp++;
        if ({kp, ki, kd, sp, busy, param_upd} !== {32'h11223344, 1'b0, 1'b1}) begin
            n_mis++;
            $display("FAIL commit_edge: got %h busy=%b upd=%b, required 11223344 busy=0 upd=1",
                     {kp, ki, kd, sp}, busy, param_upd);
        end
        cyc(1);
        n_cmp++;
        if (param_upd !== 1'b0) begin
            n_mis++;
            $display("FAIL upd_width: got %b, required 0", param_upd);
        end
        cyc(2);
        n_cmp++;
        if ((upd_cnt - u0) !== 1 || exp_q.size() !== 0) begin
            n_mis++;
            $display("FAIL commit_count: got %0d pulses (%0d pending), required 1 (0)",
                     upd_cnt - u0, exp_q.size());
        end
    endtask

    task automatic test_reject();
        int u0;
        u0 = upd_cnt;
        spi_frame(31, 32'hDEADBEEF);
        cyc(6);
        spi_frame(33, 32'hCAFEF00D);
        cyc(6);
        strobe();
        cyc(2);
        n_cmp++;
        if (err_cnt !== 4'd2) begin
            n_mis++;
            $display("FAIL reject_err: got %0d, required 2", err_cnt);
        end
        n_cmp++;
        if ({kp, ki, kd, sp} !== 32'h11223344) begin
            n_mis++;
            $display("FAIL reject_hold: got %h, required 11223344", {kp, ki, kd, sp});
        end
        n_cmp++;
        if ((upd_cnt - u0) !== 0 || busy !== 1'b0) begin
            n_mis++;
            $display("FAIL reject_upd: got %0d pulses busy=%b, required 0 busy=0", upd_cnt - u0, busy);
        end
    endtask

    task automatic test_supersede();
        int u0;
        u0 = upd_cnt;
        spi_frame(32, 32'hAABBCCDD);
        cyc(6);
        spi_frame(32, 32'h01020304);
        cyc(6);
        exp_q.push_back(32'h01020304);
        strobe();
        n_cmp++;
        if ({kp, ki, kd, sp} !== 32'h01020304) begin
            n_mis++;
            $display("FAIL supersede_val: got %h, required 01020304", {kp, ki, kd, sp});
        end
        cyc(3);
        n_cmp++;
        if ((upd_cnt - u0) !== 1 || exp_q.size() !== 0 || err_cnt !== 4'd2) begin
            n_mis++;
            $display("FAIL supersede_cnt: got %0d pulses err=%0d, required 1 err=2", upd_cnt - u0, err_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int u0;
        u0 = upd_cnt;
        spi_frame(32, 32'h55667788);
        cyc(6);
        // cs fall reaches the FSM on the third edge; strobe is sampled on that same edge.
        cs = 1'b0;
        cyc(2);
        pid_stb = 1'b1;
        exp_q.push_back(32'h55667788);
        @(posedge clk);
        #1;
        pid_stb = 1'b0;
        n_cmp++;
        if ({kp, ki, kd, sp, param_upd, busy} !== {32'h55667788, 1'b1, 1'b1}) begin
            n_mis++;
            $display("FAIL b2b_commit: got %h upd=%b busy=%b, required 55667788 upd=1 busy=1",
                     {kp, ki, kd, sp}, param_upd, busy);
        end
        #10;
        frame = 32'h5A6B7C8D;
        spi_bits(32);
        #40;
        cs = 1'b1;
        cyc(6);
        exp_q.push_back(32'h5A6B7C8D);
        strobe();
        n_cmp++;
        if ({kp, ki, kd, sp} !== 32'h5A6B7C8D) begin
            n_mis++;
            $display("FAIL b2b_second: got %h, required 5A6B7C8D", {kp, ki, kd, sp});
        end
        cyc(3);
        n_cmp++;
        if ((upd_cnt - u0) !== 2 || exp_q.size() !== 0 || err_cnt !== 4'd2) begin
            n_mis++;
            $display("FAIL b2b_count: got %0d pulses err=%0d, required 2 err=2", upd_cnt - u0, err_cnt);
        end
    endtask

    task automatic test_err_sat();
        int e;
        apply_reset();
        for (int i = 0; i < 17; i++) begin
            cs = 1'b0;
            #40;
            cs = 1'b1;
            cyc(6);
            e = (i + 1 > 15) ? 15 : i + 1;
            n_cmp++;
            if (err_cnt !== 4'(e)) begin
                n_mis++;
                $display("FAIL err_sat[%0d]: got %0d, required %0d", i, err_cnt, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        int u0;
        spi_frame(32, 32'hA1B2C3D4);
        cyc(6);
        exp_q.push_back(32'hA1B2C3D4);
        strobe();
        cyc(3);
        u0 = upd_cnt;
        frame = 32'h12345678;
        cs = 1'b0;
        #40;
        spi_bits(20);
        #3;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({kp, ki, kd, sp, busy, err_cnt, param_upd} !== {DEFAULTS, 1'b0, 4'd0, 1'b0}) begin
            n_mis++;
            $display("FAIL midreset_async: got %h busy=%b err=%0d upd=%b, required %h busy=0 err=0 upd=0",
                     {kp, ki, kd, sp}, busy, err_cnt, param_upd, DEFAULTS);
        end
        #6;
        reset_n = 1'b1;
        spi_bits(12);
        #40;
        cs = 1'b1;
        cyc(6);
        strobe();
        cyc(3);
        n_cmp++;
        if ({kp, ki, kd, sp} !== DEFAULTS || (upd_cnt - u0) !== 0) begin
            n_mis++;
            $display("FAIL midreset_nocommit: got %h (%0d pulses), required %h (0)",
                     {kp, ki, kd, sp}, upd_cnt - u0, DEFAULTS);
        end
        n_cmp++;
        if (err_cnt !== 4'd1 || busy !== 1'b0) begin
            n_mis++;
            $display("FAIL midreset_tail: got err=%0d busy=%b, required err=1 busy=0", err_cnt, busy);
        end
    endtask

    initial begin
        test_reset();
        test_commit();
        test_reject();
        test_supersede();
        test_back_to_back();
        test_err_sat();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/pid_param_commit.md
Name: pid_param_commit

Overview:
- Sits directly downstream of the SPI input shifter and consumes its parallel frame buffer.
- Runs its own frame accounting (bit count between CS assertions), validates each frame and stages it.
- Commits the staged fields to the PID core's coefficient/setpoint registers only on a PID sample strobe, so the loop never sees a half-updated parameter set.

Parameters:
- BITS, 32, frame width; must equal the upstream shifter's width.
- DEF_KP, 8'h4A, kp value after reset.
- DEF_KI, 8'h23, ki value after reset.
- DEF_KD, 8'h00, kd value after reset.
- DEF_SP, 8'h10, setpoint value after reset.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cs  in  1  raw SPI chip select, active-low, asynchronous to clk.
- sck  in  1  raw SPI clock, asynchronous to clk.
- frame  in  BITS  upstream shift buffer; stable while cs is high.
- pid_stb  in  1  one-cycle PID sample strobe.
- kp  out  8  committed proportional gain.
- ki  out  8  committed integral gain.
- kd  out  8  committed derivative gain.
- sp  out  8  committed setpoint.
- param_upd  out  1  one-cycle pulse in the cycle after a commit.
- busy  out  1  high whenever state != IDLE.
- err_cnt  out  4  saturating count of rejected frames.

Behaviour:
- Reset (async, reset_n=0):
  - kp/ki/kd/sp = DEF_*; param_upd=0; busy=0; err_cnt=0.
  - State IDLE; bit count bc=0; staging=0.
  - Synchronizer flops: cs chain=1, sck chain=0.
- Synchronization:
  - cs and sck each pass through a 2-flop synchronizer, giving cs_s and sck_s.
  - A further register of each (cs_q, sck_q) provides edge detection.
  - sck falling edge: sck_s=0 && sck_q=1. cs rise/fall is detected the same way.
- Field map:
  - frame[31:24]=kp, [23:16]=ki, [15:8]=kd, [7:0]=sp.
  - For BITS>32 only the low 32 bits are used.
- bc: width $clog2(BITS)+2; counts sck falling edges; saturates at BITS+1, so overlong frames stay distinguishable.
- State IDLE:
  - cs falling -> RECV, bc<=0.
  - sck edges are ignored.
- State RECV:
  - Each sck falling edge while cs_s=0: bc<=min(bc+1, BITS+1).
  - cs rising -> CHECK. An sck edge in the same cycle as the cs rise is not counted.
- State CHECK (exactly 1 cycle):
  - bc==BITS: staging<=frame[31:0], -> PEND.
  - Otherwise: err_cnt<=sat15(err_cnt+1), -> IDLE; outputs unchanged.
- State PEND:
  - pid_stb=1: kp/ki/kd/sp<=staging fields, param_upd<=1 next cycle, -> IDLE.
  - cs falling with no pid_stb: staging is superseded (no error), bc<=0, -> RECV.
  - pid_stb and cs falling in the same cycle: commit first, then -> RECV with bc<=0.
  - pid_stb outside PEND has no effect.
- Latency:
  - From the pin-level cs rising edge to the CHECK cycle: 3 clk cycles (2 sync + edge register).
  - Commit: outputs change on the clk edge that samples pid_stb=1 in PEND; param_upd is high for the following cycle only.
- err_cnt holds at 15 (no wrap).
- Mid-frame reset aborts everything: no partial commit, and outputs return to defaults.
- A zero-bit frame (cs pulse with no sck) is rejected and counted.

Decomposition:
- Shared package pid_pkg holds:
  - the state enum: IDLE, RECV, CHECK, PEND;
  - field offset constants KP_MSB..SP_LSB;
  - the default coefficient constants reused as parameter defaults;
  - ERR_MAX=15.
- One sub-module, sync2: a generic 2-flop synchronizer with a reset-value parameter, instantiated for cs (reset 1) and sck (reset 0).
- The FSM, counter, staging and output registers stay in pid_param_commit.

Test Plan:
- Release reset, no SPI activity -> kp=8'h4A, ki=8'h23, kd=8'h00, sp=8'h10, busy=0, err_cnt=0.
- 32-bit frame 32'h11223344, then pid_stb 5 cycles after cs rise -> param_upd pulses once; kp=11, ki=22, kd=33, sp=44; busy falls in the same cycle.
- 31-bit frame, then 33-bit frame -> both rejected, err_cnt=2, outputs unchanged, no param_upd.
- Valid frame 32'hAABBCCDD, then a second valid frame 32'h01020304 before any pid_stb, then pid_stb -> outputs 01/02/03/04, single param_upd.
- Valid frame, then pid_stb in the same cycle as the next cs fall -> first frame committed; block in RECV with bc=0.
- 17 rejected frames -> err_cnt saturates at 15.
- reset_n pulsed low mid-frame at bit 20 -> defaults restored immediately (async), IDLE, no commit.
